// File: rtl/deserializador_6bit_pkg.sv
// Shared definitions for the framed serial receiver and the 6-bit comparator stages:
// FSM encoding, frame bit levels and default word width.
package deserializador_6bit_pkg;

  localparam int ANCHO_DEFECTO   = 6;
  localparam int TIMEOUT_DEFECTO = 16;

  localparam logic START = 1'b0;
  localparam logic STOP  = 1'b1;

  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] DATOS   = 2'd1;
  localparam logic [1:0] PARIDAD = 2'd2;
  localparam logic [1:0] PARADA  = 2'd3;

endpackage

// File: rtl/deserializador_6bit_contador_timeout.sv
// Inter-bit idle counter: clears on request, counts while enabled, saturates at TIMEOUT
// and flags the terminal count.
module contador_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic fin_o
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cuenta_q, cuenta_d;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    cuenta_d = cuenta_q;
    if (clr_i) begin
      cuenta_d = '0;
    end else if (en_i && (cuenta_q != W'(TIMEOUT))) begin
      cuenta_d = cuenta_q + W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign fin_o = (cuenta_q == W'(TIMEOUT));

endmodule

// File: rtl/deserializador_6bit.sv
// Framed serial receiver: start, ANCHO data bits MSB first, even parity, stop.
// Presents the last good word held, with one-cycle valid/error pulses.
module deserializador_6bit
  import deserializador_6bit_pkg::*;
#(
  parameter int ANCHO   = ANCHO_DEFECTO,
  parameter int TIMEOUT = TIMEOUT_DEFECTO
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             DatoSerie,
  input  logic             ValidoSerie,
  output logic [ANCHO-1:0] Numero,
  output logic             NumeroValido,
  output logic             ErrorTrama,
  output logic             Ocupado
);

  localparam int CW = $clog2(ANCHO + 1);

  logic [1:0]       estado_q, estado_d;
  logic [CW-1:0]    bits_q, bits_d;
  logic [ANCHO-1:0] despl_q, despl_d;
  logic             err_par_q, err_par_d;
  logic [ANCHO-1:0] numero_q, numero_d;
  logic             valido_q, valido_d;
  logic             error_q, error_d;
  logic             tmo_fin;
  logic             en_trama;

  assign en_trama = (estado_q != REPOSO);

  contador_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i(Clk),
    .rst_i(Reset),
    .clr_i(ValidoSerie || !en_trama),
    .en_i (en_trama),
    .fin_o(tmo_fin)
  );

  always_comb begin
    estado_d  = estado_q;
    bits_d    = bits_q;
    despl_d   = despl_q;
    err_par_d = err_par_q;
    numero_d  = numero_q;
    valido_d  = 1'b0;
    error_d   = 1'b0;

    // An expired inter-bit gap abandons the frame even if a strobe shows up now.
    if (en_trama && tmo_fin) begin
      error_d  = 1'b1;
      estado_d = REPOSO;
    end else if (ValidoSerie) begin
      case (estado_q)
        REPOSO: begin
          if (DatoSerie == START) begin
            estado_d = DATOS;
            bits_d   = '0;
          end
        end
        DATOS: begin
          despl_d = ANCHO'({despl_q, DatoSerie});
          bits_d  = bits_q + CW'(1);
          if (bits_q == CW'(ANCHO - 1)) begin
            estado_d = PARIDAD;
          end
        end
        PARIDAD: begin
          err_par_d = DatoSerie ^ (^despl_q);
          estado_d  = PARADA;
        end
        default: begin
          if ((DatoSerie == STOP) && !err_par_q) begin
            numero_d = despl_q;
            valido_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
          estado_d = REPOSO;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      estado_q  <= REPOSO;
      bits_q    <= '0;
      despl_q   <= '0;
      err_par_q <= 1'b0;
      numero_q  <= '0;
      valido_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      bits_q    <= bits_d;
      despl_q   <= despl_d;
      err_par_q <= err_par_d;
      numero_q  <= numero_d;
      valido_q  <= valido_d;
      error_q   <= error_d;
    end
  end

  assign Numero       = numero_q;
  assign NumeroValido = valido_q;
  assign ErrorTrama   = error_q;
  assign Ocupado      = en_trama;

endmodule

// File: tb/tb_deserializador_6bit.sv
// Scoreboard bench: the driver pushes the expected pulse (kind, word, cycle) per frame,
// and a negedge monitor pops and compares whenever a pulse appears.
module tb_deserializador_6bit;

  localparam int TIMEOUT = 16;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       DatoSerie;
  logic       ValidoSerie;
  logic [5:0] Numero;
  logic       NumeroValido;
  logic       ErrorTrama;
  logic       Ocupado;

  typedef struct {
    bit         es_error;
    logic [5:0] valor;
    int         ciclo;
  } esperado_t;

  esperado_t  cola[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [5:0] ultimo_bueno = '0;

  deserializador_6bit #(
    .ANCHO  (6),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .DatoSerie   (DatoSerie),
    .ValidoSerie (ValidoSerie),
    .Numero      (Numero),
    .NumeroValido(NumeroValido),
    .ErrorTrama  (ErrorTrama),
    .Ocupado     (Ocupado)
  );

  initial forever #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string nombre, input int actual, input int requerido);
    checks++;
    if (actual != requerido) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nombre, actual, requerido, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard in kind, cycle and word.
  always @(negedge Clk) begin
    if (NumeroValido || ErrorTrama) begin
      esperado_t e;
      check("pulsos_exclusivos", int'(NumeroValido && ErrorTrama), 0);
      check("ocupado_con_pulso", int'(Ocupado), 0);
      if (cola.size() == 0) begin
        check("pulso_inesperado", 1, 0);
      end else begin
        e = cola.pop_front();
        check("tipo_pulso", int'(ErrorTrama), int'(e.es_error));
        check("ciclo_pulso", cyc, e.ciclo);
        if (!e.es_error) ultimo_bueno = e.valor;
        check("numero", int'(Numero), int'(ultimo_bueno));
      end
    end
  end

  function automatic int gap_aleatorio(input int max_gap);
    if (max_gap == 0) return 0;
    return ($urandom_range(0, 3) == 0) ? max_gap : int'($urandom_range(0, max_gap));
  endfunction

  // One strobe after 'gap' idle cycles; returns the index of the consuming edge.
  task automatic send_bit(input logic b, input int gap, output int edge_idx);
    repeat (gap) begin
      @(posedge Clk);
      #1;
    end
    DatoSerie   = b;
    ValidoSerie = 1'b1;
    @(posedge Clk);
    #1;
    ValidoSerie = 1'b0;
    DatoSerie   = 1'($urandom);
    edge_idx    = cyc;
  endtask

  task automatic send_frame(input logic [5:0] v, input bit mala_par, input bit mala_stop,
                            input int max_gap);
    int   e;
    logic par;
    logic stop;
    bit   buena;
    par  = (^v) ^ mala_par;
    stop = !mala_stop;
    send_bit(1'b0, gap_aleatorio(max_gap), e);
    for (int i = 5; i >= 0; i--) send_bit(v[i], gap_aleatorio(max_gap), e);
    send_bit(par, gap_aleatorio(max_gap), e);
    send_bit(stop, gap_aleatorio(max_gap), e);
    // A frame is good when data ones plus parity is even and the stop bit is 1.
    buena = ((($countones(v) + int'(par)) % 2) == 0) && (stop == 1'b1);
    cola.push_back('{es_error: !buena, valor: v, ciclo: e});
  endtask

  initial begin
    int e;
    Reset       = 1'b1;
    ValidoSerie = 1'b0;
    DatoSerie   = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_numero", int'(Numero), 0);
    check("reset_valido", int'(NumeroValido), 0);
    check("reset_error", int'(ErrorTrama), 0);
    check("reset_ocupado", int'(Ocupado), 0);
    Reset = 1'b0;

    // Directed frames: good 22, parity error, stop error on 63.
    send_frame(6'd22, 1'b0, 1'b0, 0);
    send_frame(6'd22, 1'b1, 1'b0, 0);
    send_frame(6'd63, 1'b0, 1'b1, 0);

    // Timeout: start plus three data bits, then silence. Counter reaches TIMEOUT
    // TIMEOUT edges after the last strobe; the pulse registers one edge later.
    send_bit(1'b0, 2, e);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0, e);
    cola.push_back('{es_error: 1'b1, valor: 6'd0, ciclo: e + TIMEOUT + 1});
    repeat (TIMEOUT) begin
      @(posedge Clk);
      #1;
    end
    check("ocupado_antes_timeout", int'(Ocupado), 1);
    @(posedge Clk);
    #1;
    check("ocupado_tras_timeout", int'(Ocupado), 0);
    send_frame(6'd5, 1'b0, 1'b0, 0);

    // Reset in the middle of a frame, after the 4th data bit.
    send_bit(1'b0, 1, e);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0, e);
    Reset = 1'b1;
    #1;
    check("rst_medio_numero", int'(Numero), 0);
    check("rst_medio_valido", int'(NumeroValido), 0);
    check("rst_medio_error", int'(ErrorTrama), 0);
    check("rst_medio_ocupado", int'(Ocupado), 0);
    ultimo_bueno = '0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    send_frame(6'd0, 1'b0, 1'b0, 0);

    // Sweep all values back to back, strobes sometimes gapped by TIMEOUT-1 cycles.
    for (int v = 0; v < 64; v++) send_frame(6'(v), 1'b0, 1'b0, TIMEOUT - 1);

    // Random frames with idle-line strobes, random gaps and random corruption.
    for (int n = 0; n < 24; n++) begin
      int idles;
      idles = int'($urandom_range(0, 2));
      for (int k = 0; k < idles; k++) send_bit(1'b1, int'($urandom_range(0, 3)), e);
      send_frame(6'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 TIMEOUT - 1);
    end

    repeat (2 * TIMEOUT) @(posedge Clk);
    #1;
    check("cola_vacia", cola.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
